// File: rtl/uart_tx_shift.sv
// rtl/uart_tx_shift.sv - UART transmit shift path; optional parity bit with UART_TX_PARITY_EN.
module uart_tx_shift #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 8 || OVERSAMPLE < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_tx_shift: parameter out of range");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic parity;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // tx_ready is always high here; a tick on the accept cycle is dropped
          if (tx_valid) begin
            shift    <= tx_data;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
`ifdef UART_TX_PARITY_EN
            parity   <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        default: begin
          if (tick) begin
            if (tick_cnt != TW'(OVERSAMPLE - 1)) begin
              tick_cnt <= tick_cnt + TW'(1);
            end else begin
              tick_cnt <= '0;
              case (state)
                START: begin
                  tx    <= shift[0];
                  state <= DATA;
                end
                DATA: begin
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + BW'(1);
                  if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    tx    <= parity;
                    state <= PARITY;
`else
                    tx       <= 1'b1;
                    stop_cnt <= 1'b0;
                    state    <= STOP;
`endif
                  end else begin
                    tx <= shift[1];
                  end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                  tx       <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= STOP;
                end
`endif
                STOP: begin
                  if (stop_cnt == 1'(STOP_BITS - 1)) begin
                    state    <= IDLE;
                    done     <= 1'b1;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                  end else begin
                    stop_cnt <= stop_cnt + 1'b1;
                  end
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_shift.sv
// tb/tb_uart_tx_shift.sv - directed vector bench for uart_tx_shift.
module tb_uart_tx_shift;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    int         sel;   // 0: OS16/S1/even, 1: OS16/S2/odd, 2: OS4/S1/even
    logic [7:0] data;
    logic [9:0] line;  // bit i = i-th level sent: start, d0..d7, stop
    logic       par;   // parity bit for that instance's sense
    int         tper;  // clk cycles per tick
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] tick_v, valid_v, tx_v, ready_v, busy_v, done_v;
  logic [7:0] data_v [3];
  int         tests = 0;
  int         fails = 0;
  vec_t       tbl [6];

  always #5 clk = ~clk;

  uart_tx_shift #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst(rst), .tick(tick_v[0]), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx_shift #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(2), .PARITY_ODD(1)) u1 (
    .clk(clk), .rst(rst), .tick(tick_v[1]), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx_shift #(.DATA_BITS(8), .OVERSAMPLE(4), .STOP_BITS(1), .PARITY_ODD(0)) u2 (
    .clk(clk), .rst(rst), .tick(tick_v[2]), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int os_of(input int sel);
    return (sel == 2) ? 4 : 16;
  endfunction

  function automatic int stop_of(input int sel);
    return (sel == 1) ? 2 : 1;
  endfunction

  task automatic run_frame(input vec_t v, input int abort_at);
    int   os, per, nb, total, b, got, seen, early;
    logic seq [16];
    os    = os_of(v.sel);
    per   = v.tper;
    nb    = 1 + 8 + P + stop_of(v.sel);
    total = nb * os * per;
    for (int i = 0; i < 16; i++) seq[i] = 1'b1;
    for (int i = 0; i < 9; i++) seq[i] = v.line[i];
`ifdef UART_TX_PARITY_EN
    seq[9] = v.par;
`endif
    early = 0;
    got   = 0;
    @(negedge clk);
    chk("ready_before_accept", ready_v[v.sel], 1);
    data_v[v.sel]  = v.data;
    valid_v[v.sel] = 1'b1;
    tick_v[v.sel]  = 1'b1;
    @(negedge clk);
    valid_v[v.sel] = 1'b0;
    data_v[v.sel]  = ~v.data;
    chk("busy_after_accept", busy_v[v.sel], 1);
    for (int n = 0; n <= total; n++) begin
      if (n == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_tx_high", tx_v[v.sel], 1);
        chk("abort_busy", busy_v[v.sel], 0);
        chk("abort_ready", ready_v[v.sel], 1);
        seen = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
          @(negedge clk);
          if (done_v[v.sel]) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        return;
      end
      if (n < total) begin
        b = n / (os * per);
        if (n % (os * per) == 0) got = seq[b];
        if (tx_v[v.sel] != seq[b]) got = tx_v[v.sel];
        if (done_v[v.sel]) early = 1;
        if (n % (os * per) == os * per - 1)
          chk($sformatf("sel%0d_data%02h_bit%0d", v.sel, v.data, b), got, seq[b]);
        tick_v[v.sel] = ((n + 1) % per == 0);
        @(negedge clk);
      end else begin
        chk($sformatf("sel%0d_done_at_%0d", v.sel, total), done_v[v.sel], 1);
        chk("ready_with_done", ready_v[v.sel], 1);
        chk("busy_with_done", busy_v[v.sel], 0);
        @(negedge clk);
        chk("done_one_cycle", done_v[v.sel], 0);
      end
    end
    chk("no_early_done", early, 0);
  endtask

  task automatic back_to_back();
    int n, m, run, total;
    total = (1 + 8 + P + 2) * 16;
    run   = 0;
    @(negedge clk);
    data_v[1]  = 8'h00;
    valid_v[1] = 1'b1;
    tick_v[1]  = 1'b1;
    @(negedge clk);
    data_v[1] = 8'hFF;
    n = 0;
    while (!done_v[1] && n < 400) begin
      if (n == 4 * 16 + 8) chk("b2b_first_byte_held", tx_v[1], 0);
      run = tx_v[1] ? run + 1 : 0;
      @(negedge clk);
      n++;
    end
    if (tx_v[1]) run++;
    chk("b2b_done1", n, total);
    chk("b2b_high_run", run, 2 * 16 + 1 + 16 * P);
    @(negedge clk);
    chk("b2b_start_immediate", tx_v[1], 0);
    chk("b2b_busy_again", busy_v[1], 1);
    valid_v[1] = 1'b0;
    m = 0;
    while (!done_v[1] && m < 400) begin
      if (m == 16 + 8) chk("b2b_second_byte", tx_v[1], 1);
      @(negedge clk);
      m++;
    end
    chk("b2b_done2", m, total);
  endtask

  initial begin
    int bad;
    tbl[0] = '{0, 8'hA5, 10'b1101001010, 1'b0, 1};
    tbl[1] = '{0, 8'h01, 10'b1000000010, 1'b1, 1};
    tbl[2] = '{0, 8'hFF, 10'b1111111110, 1'b0, 1};
    tbl[3] = '{1, 8'hA5, 10'b1101001010, 1'b1, 1};
    tbl[4] = '{2, 8'h3C, 10'b1001111000, 1'b0, 5};
    tbl[5] = '{0, 8'h80, 10'b1100000000, 1'b1, 1};
    tick_v  = '0;
    valid_v = '0;
    for (int i = 0; i < 3; i++) data_v[i] = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx_v[0], 1);
    chk("reset_ready", ready_v[0], 1);
    chk("reset_busy", busy_v[0], 0);
    chk("reset_done", done_v[0], 0);
    rst    = 1'b0;
    tick_v = 3'b111;
    bad    = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_v != 3'b111 || ready_v != 3'b111 || busy_v != 3'b000 || done_v != 3'b000) bad++;
    end
    chk("idle_200_bad_cycles", bad, 0);
    for (int i = 0; i < 6; i++) run_frame(tbl[i], -1);
    run_frame(tbl[0], 50);
    run_frame(tbl[0], -1);
    back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
